// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states, word width
// and the word-address width helper.
package instruction_memory_loader_pkg;

   localparam int INSTR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   // A word address drops the two byte-offset bits of the byte address.
   function automatic int word_addr_bits(input int memory_size);
      return $clog2(memory_size) - 2;
   endfunction

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Loader bundle: load request, source stream handshake, memory write port
// and core/status signals.
interface instruction_memory_loader_if
   import instruction_memory_loader_pkg::*;
#(
   parameter int W = word_addr_bits(1024)
);
   logic                   start;
   logic [W-1:0]           base_word_address;
   logic [W:0]             word_count;
   logic [INSTR_WIDTH-1:0] in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic                   mem_write_enable;
   logic [W-1:0]           mem_address;
   logic [INSTR_WIDTH-1:0] mem_write_data;
   logic                   core_hold;
   logic                   busy;
   logic                   done;
   logic                   error;

   modport master (
      output start, base_word_address, word_count, in_data, in_valid,
      input  in_ready, mem_write_enable, mem_address, mem_write_data,
             core_hold, busy, done, error
   );

   modport slave (
      input  start, base_word_address, word_count, in_data, in_valid,
      output in_ready, mem_write_enable, mem_address, mem_write_data,
             core_hold, busy, done, error
   );
endinterface

// File: rtl/instruction_memory_loader_write_stage_register.sv
// One-cycle register between an accepted word and the memory write port;
// address and data hold their last values when no strobe is issued.
module write_stage_register
   import instruction_memory_loader_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   xfer_i,
   input  logic [W-1:0]           addr_i,
   input  logic [INSTR_WIDTH-1:0] data_i,
   output logic                   we_o,
   output logic [W-1:0]           addr_o,
   output logic [INSTR_WIDTH-1:0] data_o
);
   logic                   we_q;
   logic [W-1:0]           addr_q;
   logic [INSTR_WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q <= xfer_i;
         if (xfer_i) begin
            addr_q <= addr_i;
            data_q <= data_i;
         end
      end
   end

   assign we_o   = we_q;
   assign addr_o = addr_q;
   assign data_o = data_q;
endmodule

// File: rtl/instruction_memory_loader.sv
// Streams instruction words into consecutive instruction memory word
// addresses while holding the core in stall.
//
// state | meaning
// IDLE  | waiting for start; range check and latch of base/count
// LOAD  | accepting words, one write per accepted word
// FLUSH | final write strobe leaves the write stage
// DONE  | one-cycle completion pulse, core released
module instruction_memory_loader
   import instruction_memory_loader_pkg::*;
#(
   parameter int memory_size         = 1024,
   parameter int memory_address_bits = $clog2(memory_size),
   parameter int word_bits           = memory_address_bits - 2
) (
   input  logic                         clk,
   input  logic                         reset,
   instruction_memory_loader_if.slave   bus
);
   localparam int W     = word_bits;
   localparam int DEPTH = memory_size / 4;
   localparam logic [W+1:0] DEPTH_L = (W+2)'(DEPTH);

   loader_state_t state_q, state_d;
   logic [W-1:0]  ptr_q, ptr_d;
   logic [W:0]    rem_q, rem_d;
   logic          error_q, error_d;

   logic          in_ready;
   logic          busy;
   logic          core_hold;
   logic          done;
   logic          xfer;
   logic [W+1:0]  range_end;

   // Widened so base + count can never wrap before the depth compare.
   assign range_end = (W+2)'(bus.base_word_address) + (W+2)'(bus.word_count);
   assign xfer      = in_ready && bus.in_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      error_d   = 1'b0;
      in_ready  = 1'b0;
      busy      = 1'b0;
      core_hold = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (range_end > DEPTH_L) begin
                  error_d = 1'b1;
               end else if (bus.word_count == '0) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = bus.base_word_address;
                  rem_d   = bus.word_count;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            in_ready  = 1'b1;
            busy      = 1'b1;
            core_hold = 1'b1;
            if (bus.in_valid) begin
               ptr_d = ptr_q + W'(1);
               rem_d = rem_q - (W+1)'(1);
               if (rem_q == (W+1)'(1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            busy      = 1'b1;
            core_hold = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   write_stage_register #(.W(W)) u_write_stage (
      .clk    (clk),
      .reset  (reset),
      .xfer_i (xfer),
      .addr_i (ptr_q),
      .data_i (bus.in_data),
      .we_o   (bus.mem_write_enable),
      .addr_o (bus.mem_address),
      .data_o (bus.mem_write_data)
   );

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy;
   assign bus.core_hold = core_hold;
   assign bus.done      = done;
   assign bus.error     = error_q;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: accepted words are queued as
// expected writes and a negedge monitor matches them against memory strobes.
module tb_instruction_memory_loader;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   logic [W+31:0] exp_q[$];
   logic [31:0]   word_buf[256];

   instruction_memory_loader_if #(.W(W)) bus();

   instruction_memory_loader #(.memory_size(1024)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued accept.
   always @(negedge clk) begin
      if (bus.mem_write_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h expected no write",
                     bus.mem_address, bus.mem_write_data);
         end else begin
            logic [W+31:0] e;
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.mem_address), 32'(e[W+31:32]));
            check("write_data", bus.mem_write_data, e[31:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int base, input int count);
      bus.start             = 1'b1;
      bus.base_word_address = W'(base);
      bus.word_count        = (W+1)'(count);
      tick();
      bus.start = 1'b0;
   endtask

   // Streams n words from word_buf; valid follows vpat (period vlen). When
   // inj >= 0 a conflicting start is raised on that cycle.
   task automatic stream(input int base, input int n, input logic [15:0] vpat,
                         input int vlen, input int inj);
      int i;
      int cyc;
      i   = 0;
      cyc = 0;
      while (i < n) begin
         if (cyc > 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout: got %0d accepts expected %0d", i, n);
            break;
         end
         bus.in_valid = vpat[cyc % vlen];
         bus.in_data  = word_buf[i];
         if (inj >= 0 && cyc == inj) begin
            bus.start             = 1'b1;
            bus.base_word_address = W'(100);
            bus.word_count        = (W+1)'(5);
         end else begin
            bus.start = 1'b0;
         end
         #1;
         check("load_in_ready", 32'(bus.in_ready), 32'd1);
         check("load_core_hold", 32'(bus.core_hold), 32'd1);
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({W'(base + i), word_buf[i]});
            i++;
         end
         tick();
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask

   task automatic finish_check();
      check("flush_in_ready", 32'(bus.in_ready), 32'd0);
      check("flush_busy", 32'(bus.busy), 32'd1);
      check("flush_core_hold", 32'(bus.core_hold), 32'd1);
      check("flush_done", 32'(bus.done), 32'd0);
      tick();
      check("done_pulse", 32'(bus.done), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd0);
      check("done_core_hold", 32'(bus.core_hold), 32'd0);
      tick();
      check("done_cleared", 32'(bus.done), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_we"}, 32'(bus.mem_write_enable), 32'd0);
      check({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
      check({tag, "_data"}, bus.mem_write_data, 32'd0);
      check({tag, "_core_hold"}, 32'(bus.core_hold), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_error"}, 32'(bus.error), 32'd0);
   endtask

   initial begin
      vectors               = 0;
      miscompares           = 0;
      reset                 = 1'b1;
      bus.start             = 1'b0;
      bus.base_word_address = '0;
      bus.word_count        = '0;
      bus.in_data           = '0;
      bus.in_valid          = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Basic back-to-back load
      word_buf[0] = 32'h0000_0013;
      word_buf[1] = 32'h0010_0093;
      word_buf[2] = 32'h0020_0113;
      word_buf[3] = 32'h0030_8193;
      do_start(0, 4);
      stream(0, 4, 16'h0001, 1, -1);
      finish_check();

      // Source stalls: valid 1,0,0,1,0,1
      word_buf[0] = 32'hDEAD_0001;
      word_buf[1] = 32'hDEAD_0002;
      word_buf[2] = 32'hDEAD_0003;
      do_start(10, 3);
      stream(10, 3, 16'b10_1001, 6, -1);
      finish_check();

      // Range overflow: 250 + 10 > 256
      do_start(250, 10);
      check("error_pulse", 32'(bus.error), 32'd1);
      check("error_busy", 32'(bus.busy), 32'd0);
      check("error_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("error_cleared", 32'(bus.error), 32'd0);
      check("error_stays_idle", 32'(bus.busy), 32'd0);

      // Zero count goes straight to DONE
      do_start(5, 0);
      check("zero_done", 32'(bus.done), 32'd1);
      check("zero_busy", 32'(bus.busy), 32'd0);
      tick();
      check("zero_done_cleared", 32'(bus.done), 32'd0);

      // Exactly full memory
      for (int k = 0; k < 256; k++) word_buf[k] = 32'hA500_0000 | 32'(k * 3);
      do_start(0, 256);
      stream(0, 256, 16'h0001, 1, -1);
      finish_check();

      // Top slot only
      word_buf[0] = 32'h1234_5678;
      do_start(255, 1);
      stream(255, 1, 16'h0001, 1, -1);
      finish_check();

      // Reset after the 3rd accept of an 8-word load
      for (int k = 0; k < 8; k++) word_buf[k] = 32'hC0DE_0000 | 32'(k);
      do_start(20, 8);
      stream(20, 3, 16'h0001, 1, -1);
      reset = 1'b1;
      tick();
      check_all_zero("midreset");
      reset = 1'b0;
      tick();
      check("midreset_idle", 32'(bus.busy), 32'd0);
      word_buf[0] = 32'h0BAD_F00D;
      word_buf[1] = 32'h0600_D000;
      do_start(60, 2);
      stream(60, 2, 16'h0001, 1, -1);
      finish_check();

      // start raised while loading must be ignored
      word_buf[0] = 32'h7777_0000;
      word_buf[1] = 32'h7777_0001;
      word_buf[2] = 32'h7777_0002;
      do_start(40, 3);
      stream(40, 3, 16'b1101, 4, 1);
      finish_check();
      check("ignored_start_idle", 32'(bus.busy), 32'd0);

      tick();
      tick();
      check("pending_writes", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
